// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN car controller sequencing motor, door and request-clear pulses.
// Define FAULT_WATCHDOG_EN to add the door/move watchdog and the latched FAULT state.
module elevator_scheduler #(
    parameter int NFLOORS      = 4,
    parameter int DWELL_CYCLES = 8,
    parameter int DOOR_TIMEOUT = 32,
    parameter int MOVE_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NFLOORS-1:0] req,
    input  logic [1:0]         floor,
    input  logic               at_floor,
    input  logic               door_open_lim,
    input  logic               door_closed_lim,
    input  logic               obstruction,
    output logic               motor_up,
    output logic               motor_down,
    output logic               door_open_cmd,
    output logic               door_close_cmd,
    output logic [NFLOORS-1:0] req_clr,
    output logic               dir_up,
    output logic               fault
);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
`ifdef FAULT_WATCHDOG_EN
    localparam int WW = $clog2(MOVE_TIMEOUT > DOOR_TIMEOUT ? MOVE_TIMEOUT : DOOR_TIMEOUT) + 1;
    localparam logic [WW-1:0] DOOR_LAST = WW'(DOOR_TIMEOUT - 1);
    localparam logic [WW-1:0] MOVE_LAST = WW'(MOVE_TIMEOUT - 1);
    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DN, OPEN, DWELL, CLOSE, FAULT} state_t;
    logic [WW-1:0] wd;
`else
    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DN, OPEN, DWELL, CLOSE} state_t;
`endif
    state_t state;
    logic [DW-1:0] cnt;
    logic [3:0] rq, cur, clr_q;
    logic dir_q, at_q, rise, here, above, below, end_floor;
    // Floors beyond NFLOORS read as never requested.
    for (genvar i = 0; i < 4; i++) begin : g_rq
        if (i < NFLOORS) begin : g_on
            assign rq[i] = req[i];
        end else begin : g_off
            assign rq[i] = 1'b0;
        end
    end
    assign cur       = 4'(1) << floor;
    assign here      = rq[floor];
    assign rise      = at_floor & ~at_q;
    assign end_floor = state == MOVE_UP ? floor == 2'(NFLOORS - 1) : floor == 2'd0;
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < 4; i++) begin
            above = above | (rq[i] && i > int'(floor));
            below = below | (rq[i] && i < int'(floor));
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            dir_q <= 1'b1;
            cnt   <= '0;
            clr_q <= '0;
            at_q  <= 1'b0;
`ifdef FAULT_WATCHDOG_EN
            wd    <= '0;
`endif
        end else begin
            at_q  <= at_floor;
            clr_q <= '0;
`ifdef FAULT_WATCHDOG_EN
            wd    <= wd + 1'b1;
`endif
            case (state)
                IDLE: begin
`ifdef FAULT_WATCHDOG_EN
                    wd <= '0;
`endif
                    if (door_closed_lim) begin
                        if (here) state <= OPEN;
                        else if (above && (dir_q || !below)) begin
                            state <= MOVE_UP;
                            dir_q <= 1'b1;
                        end else if (below) begin
                            state <= MOVE_DN;
                            dir_q <= 1'b0;
                        end
                    end
                end
                MOVE_UP, MOVE_DN: begin
                    if (rise) begin
`ifdef FAULT_WATCHDOG_EN
                        wd <= '0;
`endif
                        if (here) state <= OPEN;
                        else if (end_floor) state <= IDLE;
                    end
                end
                OPEN: begin
                    if (door_open_lim) begin
                        state <= DWELL;
                        cnt   <= '0;
                        clr_q <= cur;
                    end
                end
                DWELL: begin
`ifdef FAULT_WATCHDOG_EN
                    wd <= '0;
`endif
                    // A request still high in the pulse cycle is the one being cleared, not a new one.
                    if (here && clr_q == '0) begin
                        clr_q <= cur;
                        cnt   <= '0;
                    end else if (cnt == DWELL_LAST) state <= CLOSE;
                    else cnt <= cnt + 1'b1;
                end
                CLOSE: begin
                    if (obstruction || here) begin
                        state <= OPEN;
`ifdef FAULT_WATCHDOG_EN
                        wd    <= '0;
`endif
                    end else if (door_closed_lim) state <= IDLE;
                end
`ifdef FAULT_WATCHDOG_EN
                FAULT: wd <= '0;
`endif
                default: state <= IDLE;
            endcase
`ifdef FAULT_WATCHDOG_EN
            if (((state == OPEN || state == CLOSE) && wd == DOOR_LAST) ||
                ((state == MOVE_UP || state == MOVE_DN) && !rise && wd == MOVE_LAST)) begin
                state <= FAULT;
                clr_q <= '0;
            end
`endif
        end
    end
    assign motor_up       = state == MOVE_UP && door_closed_lim;
    assign motor_down     = state == MOVE_DN && door_closed_lim;
    assign door_open_cmd  = state == OPEN;
    assign door_close_cmd = state == CLOSE;
    assign req_clr        = clr_q[NFLOORS-1:0];
`ifdef FAULT_WATCHDOG_EN
    assign dir_up = dir_q && state != FAULT;
    assign fault  = state == FAULT;
`else
    assign dir_up = dir_q;
    assign fault  = 1'b0;
`endif
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed checks of the SCAN car controller with a simple request latch.
module tb_elevator_scheduler;
    logic clk = 1'b0, reset;
    logic [3:0] req, req_clr;
    logic [1:0] floor;
    logic at_floor, door_open_lim, door_closed_lim, obstruction;
    logic motor_up, motor_down, door_open_cmd, door_close_cmd, dir_up, fault;
    int n_chk = 0, n_fail = 0;

    elevator_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .floor(floor), .at_floor(at_floor),
        .door_open_lim(door_open_lim), .door_closed_lim(door_closed_lim),
        .obstruction(obstruction), .motor_up(motor_up), .motor_down(motor_down),
        .door_open_cmd(door_open_cmd), .door_close_cmd(door_close_cmd),
        .req_clr(req_clr), .dir_up(dir_up), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Request latch: a served request drops once its clear pulse has been seen.
    task automatic step();
        @(posedge clk);
        #1;
        req = req & ~req_clr;
    endtask

    task automatic arrive(input logic [1:0] f);
        at_floor = 1'b0;
        step();
        floor = f;
        at_floor = 1'b1;
        step();
    endtask

    task automatic open_door(input logic [3:0] exp);
        door_closed_lim = 1'b0;
        door_open_lim = 1'b1;
        step();
        check("req_clr_entry", req_clr, exp);
    endtask

    task automatic reach_close();
        repeat (7) step();
        check("dwell_not_done", door_close_cmd, 0);
        step();
        check("dwell_done", door_close_cmd, 1);
    endtask

    task automatic finish_close();
        door_open_lim = 1'b0;
        door_closed_lim = 1'b1;
        step();
        check("closed_idle", door_close_cmd, 0);
    endtask

    initial begin
        reset = 1'b0;
        req = 4'b0;
        floor = 2'd0;
        at_floor = 1'b1;
        door_open_lim = 1'b0;
        door_closed_lim = 1'b1;
        obstruction = 1'b0;
        step();
        step();
        check("rst_motor_up", motor_up, 0);
        check("rst_door_open", door_open_cmd, 0);
        check("rst_req_clr", req_clr, 0);
        check("rst_dir_up", dir_up, 1);
        check("rst_fault", fault, 0);
        reset = 1'b1;
        step();
        // 1: floor 0 to floor 1
        req = 4'b0010;
        step();
        check("t1_motor_up", motor_up, 1);
        check("t1_dir_up", dir_up, 1);
        arrive(2'd1);
        check("t1_stop_motor", motor_up, 0);
        check("t1_open", door_open_cmd, 1);
        open_door(4'b0010);
        check("t1_open_done", door_open_cmd, 0);
        step();
        check("t1_clr_one_cycle", req_clr, 0);
        repeat (6) step();
        check("t1_close_early", door_close_cmd, 0);
        step();
        check("t1_close", door_close_cmd, 1);
        finish_close();
        // 5: request at the current floor opens without moving
        req = 4'b0010;
        step();
        check("t5_open", door_open_cmd, 1);
        check("t5_no_up", motor_up, 0);
        check("t5_no_down", motor_down, 0);
        open_door(4'b0010);
        check("t5_no_motor", motor_up | motor_down, 0);
        reach_close();
        // 3: obstruction reopens, dwell restarts, reassertion re-pulses
        door_open_lim = 1'b0;
        step();
        obstruction = 1'b1;
        step();
        check("t3_reopen", door_open_cmd, 1);
        check("t3_not_close", door_close_cmd, 0);
        obstruction = 1'b0;
        open_door(4'b0010);
        repeat (3) step();
        req = 4'b0010;
        step();
        check("t3_repulse", req_clr, 4'b0010);
        reach_close();
        door_open_lim = 1'b0;
        door_closed_lim = 1'b1;
        obstruction = 1'b1;
        step();
        check("t3_obst_wins", door_open_cmd, 1);
        obstruction = 1'b0;
        open_door(4'b0010);
        reach_close();
        finish_close();
        // 4: door-closed limit gates the motor combinationally
        req = 4'b0100;
        step();
        check("t4_motor_up", motor_up, 1);
        at_floor = 1'b0;
        step();
        door_closed_lim = 1'b0;
        #1;
        check("t4_gate_same_cycle", motor_up, 0);
        step();
        check("t4_gate_hold", motor_up, 0);
        check("t4_state_hold", door_open_cmd, 0);
        door_closed_lim = 1'b1;
        #1;
        check("t4_restore", motor_up, 1);
        floor = 2'd2;
        at_floor = 1'b1;
        step();
        check("t4_open_f2", door_open_cmd, 1);
        open_door(4'b0100);
        reach_close();
        finish_close();
        // 2: SCAN up to floor 3, then reverse to floor 0
        req = 4'b1001;
        step();
        check("t2_up_first", motor_up, 1);
        check("t2_dir_up", dir_up, 1);
        arrive(2'd3);
        check("t2_open_f3", door_open_cmd, 1);
        open_door(4'b1000);
        reach_close();
        finish_close();
        step();
        check("t2_down", motor_down, 1);
        check("t2_dir_down", dir_up, 0);
        arrive(2'd2);
        check("t2_pass_f2", motor_down, 1);
        arrive(2'd1);
        check("t2_pass_f1", motor_down, 1);
        arrive(2'd0);
        check("t2_stop_f0", motor_down, 0);
        check("t2_open_f0", door_open_cmd, 1);
        open_door(4'b0001);
        reach_close();
        finish_close();
        check("t2_no_fault", fault, 0);
`ifdef FAULT_WATCHDOG_EN
        // 6: door never reaches the open limit
        req = 4'b0001;
        step();
        check("t6_open", door_open_cmd, 1);
        door_closed_lim = 1'b0;
        repeat (31) step();
        check("t6_no_fault_yet", fault, 0);
        step();
        check("t6_fault", fault, 1);
        check("t6_outputs_off", {motor_up, motor_down, door_open_cmd, door_close_cmd, dir_up, req_clr}, 0);
        reset = 1'b0;
        #1;
        check("t6_reset_clears", fault, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
